rf_riscv_sb: RTL

//  Multi-port RISC-V integer register file with a write-to-read bypass, two write ports and a per-register busy scoreboard.

---
 rtl/rf_riscv_sb.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rf_riscv_sb.sv
`default_nettype none
// ============================================================================
//  Module      : rf_riscv_sb
//  Description : RISC-V integer register file with two write ports
//                (A = in-order writeback, B = late LSU writeback), optional
//                write-to-read bypass, a per-register busy scoreboard and a
//                clear sequencer that zeroes every register after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_riscv_sb #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int c_AW  = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    output logic                    ready_o,
    input  logic [NREAD*c_AW-1:0]   rd_addr_i,
    output logic [NREAD*DWIDTH-1:0] rd_data_o,
    output logic [NREAD-1:0]        rd_busy_o,
    input  logic                    wa_en_i,
    input  logic [c_AW-1:0]         wa_addr_i,
    input  logic [DWIDTH-1:0]       wa_data_i,
    input  logic                    wb_en_i,
    input  logic [c_AW-1:0]         wb_addr_i,
    input  logic [DWIDTH-1:0]       wb_data_i,
    input  logic                    rsv_en_i,
    input  logic [c_AW-1:0]         rsv_addr_i
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_AW-1:0]     r_clr_ptr;
    logic [DWIDTH-1:0]   r_rf [0:DEPTH-1];   // entry 0 is never written nor read out
    logic [DEPTH-1:0]    r_busy;
    logic [DEPTH-1:0]    w_busy_nxt;
    logic                w_run;
    logic                w_wa_we;
    logic                w_wb_we;
    logic                w_rsv_set;

    assign w_run     = (r_state == ST_RUN);
    assign ready_o   = w_run;
    // x0 is hardwired: writes and reservations to it are dropped here.
    assign w_wa_we   = w_run && wa_en_i  && (wa_addr_i  != '0);
    assign w_wb_we   = w_run && wb_en_i  && (wb_addr_i  != '0);
    assign w_rsv_set = w_run && rsv_en_i && (rsv_addr_i != '0);

    // State register: reset always restarts the clear sequence.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_CLEAR;
        else       r_state <= w_state_nxt;
    end

    // Next state: leave CLEAR on the cycle the last register is zeroed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_ptr == c_AW'(DEPTH - 1)) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // Clear pointer starts at 1 because x0 has no storage to clear.
    always_ff @(posedge clk_i) begin
        if (rst_i)                     r_clr_ptr <= c_AW'(1);
        else if (r_state == ST_CLEAR)  r_clr_ptr <= r_clr_ptr + c_AW'(1);
    end

    // Storage: zeroed by the sequencer, then written by ports B and A
    // (A is applied last so it wins on a same-address collision).
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (r_state == ST_CLEAR) begin
                r_rf[r_clr_ptr] <= '0;
            end else begin
                if (w_wb_we) r_rf[wb_addr_i] <= wb_data_i;
                if (w_wa_we) r_rf[wa_addr_i] <= wa_data_i;
            end
        end
    end

    // Busy next value: B clears first, a reservation then sets, so set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb_we)   w_busy_nxt[wb_addr_i]  = 1'b0;
        if (w_rsv_set) w_busy_nxt[rsv_addr_i] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Busy register: reset discards all outstanding reservations.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_busy <= '0;
        else       r_busy <= w_busy_nxt;
    end

    // Combinational read ports with A-over-B bypass priority.
    genvar k;
    generate
        for (k = 0; k < NREAD; k++) begin : g_rd
            logic [c_AW-1:0] w_addr;
            logic            w_hit_a;
            logic            w_hit_b;
            logic            w_live;

            assign w_addr  = rd_addr_i[k*c_AW +: c_AW];
            assign w_live  = ready_o && (w_addr != '0);
            assign w_hit_a = (BYPASS != 0) && wa_en_i && (wa_addr_i == w_addr);
            assign w_hit_b = (BYPASS != 0) && wb_en_i && (wb_addr_i == w_addr);

            assign rd_data_o[k*DWIDTH +: DWIDTH] = !w_live ? '0        :
                                                   w_hit_a ? wa_data_i :
                                                   w_hit_b ? wb_data_i :
                                                             r_rf[w_addr];
            assign rd_busy_o[k] = w_live && r_busy[w_addr] && !w_hit_b;
        end
    endgenerate

endmodule
`default_nettype wire
